// File: rtl/act_quant_pkg.sv
// Shared encodings, defaults and helpers for the activation quantizer.
package act_quant_pkg;

    // Output precision encodings carried on cfg_prec.
    localparam logic [1:0] PREC_2B = 2'b00;
    localparam logic [1:0] PREC_4B = 2'b01;
    localparam logic [1:0] PREC_8B = 2'b10;

    // Default parameter values for the array.
    localparam int DEF_DATA_WIDTH = 28;
    localparam int DEF_LANES      = 16;
    localparam int DEF_SHIFT_W    = 4;
    localparam int DEF_SAT_CNT_W  = 16;

    // Number of output bits per lane for a precision code; the reserved
    // code 11 behaves as 8 bit.
    function automatic logic [3:0] prec_bits(input logic [1:0] prec);
        logic [3:0] bits;
        case (prec)
            PREC_2B: bits = 4'd2;
            PREC_4B: bits = 4'd4;
            PREC_8B: bits = 4'd8;
            default: bits = 4'd8;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/act_quant_lane.sv
// One quantizer lane: rounding arithmetic right shift (first register),
// then clamp to the selected precision (second register).
module act_quant_lane
    import act_quant_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SHIFT_W    = DEF_SHIFT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [SHIFT_W-1:0]           shift,
    input  logic [1:0]                   prec,
    input  logic                         linear,
    input  logic signed [DATA_WIDTH-1:0] x,
    output logic [7:0]                   q,
    output logic                         sat
);

    // One extra bit of headroom so adding the rounding constant never wraps.
    localparam int TW = DATA_WIDTH + 1;
    localparam logic signed [TW-1:0] ONE_T = {{(TW-1){1'b0}}, 1'b1};

    logic signed [TW-1:0] ext_s;
    logic signed [TW-1:0] rnd_s;
    logic signed [TW-1:0] t_d;
    logic signed [TW-1:0] t_q;
    logic signed [TW-1:0] hi_s;
    logic signed [TW-1:0] lo_s;
    logic signed [TW-1:0] clamp_s;
    logic [3:0]           p_s;
    logic [7:0]           mask_s;
    logic [7:0]           q_d;
    logic [7:0]           q_q;
    logic                 sat_d;
    logic                 sat_q;

    // Round-half-up: add half an LSB of the result before the arithmetic shift.
    always_comb begin
        ext_s = {x[DATA_WIDTH-1], x};
        if (shift != '0) begin
            rnd_s = ONE_T <<< (shift - SHIFT_W'(1));
        end else begin
            rnd_s = '0;
        end
        t_d = (ext_s + rnd_s) >>> shift;
    end

    // Clamp to the precision window; only hitting the upper bound counts as saturation.
    always_comb begin
        p_s    = prec_bits(prec);
        mask_s = 8'((9'd1 << p_s) - 9'd1);
        if (linear) begin
            hi_s = (ONE_T <<< (p_s - 4'd1)) - ONE_T;
            lo_s = -(ONE_T <<< (p_s - 4'd1));
        end else begin
            hi_s = (ONE_T <<< p_s) - ONE_T;
            lo_s = '0;
        end
        if (t_q > hi_s) begin
            clamp_s = hi_s;
            sat_d   = 1'b1;
        end else if (t_q < lo_s) begin
            clamp_s = lo_s;
            sat_d   = 1'b0;
        end else begin
            clamp_s = t_q;
            sat_d   = 1'b0;
        end
        q_d = clamp_s[7:0] & mask_s;
    end

    // Both lane pipeline registers advance together under the global enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_q   <= '0;
            q_q   <= 8'd0;
            sat_q <= 1'b0;
        end else if (en) begin
            t_q   <= t_d;
            q_q   <= q_d;
            sat_q <= sat_d;
        end
    end

    assign q   = q_q;
    assign sat = sat_q;

endmodule

// File: rtl/act_quant_pack_array.sv
// Activation quantizer array: LANES round/clamp lanes, a beat packer that
// fills 8-bit lane slots with 1/2/4 beats, back-pressure, config and a
// saturation counter.
module act_quant_pack_array
    import act_quant_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LANES      = DEF_LANES,
    parameter int SHIFT_W    = DEF_SHIFT_W,
    parameter int SAT_CNT_W  = DEF_SAT_CNT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_load,
    input  logic [1:0]                    cfg_prec,
    input  logic [SHIFT_W-1:0]            cfg_shift,
    input  logic                          cfg_linear,
    input  logic                          in_vld,
    output logic                          in_rdy,
    input  logic                          in_last,
    input  logic [DATA_WIDTH*LANES-1:0]   in_data,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [8*LANES-1:0]            out_data,
    output logic                          out_last,
    output logic [SAT_CNT_W-1:0]          sat_cnt,
    output logic                          busy
);

    localparam int CNT_W = $clog2(LANES + 1);

    logic                   en_s;
    logic                   busy_s;
    logic                   s1_vld_d, s1_vld_q, s1_last_d, s1_last_q;
    logic                   s2_vld_d, s2_vld_q, s2_last_d, s2_last_q;
    logic [1:0]             k_d, k_q;
    logic [8*LANES-1:0]     pack_d, pack_q;
    logic [8*LANES-1:0]     word_s;
    logic [8*LANES-1:0]     out_data_d, out_data_q;
    logic                   out_vld_d, out_vld_q;
    logic                   out_last_d, out_last_q;
    logic [SAT_CNT_W-1:0]   sat_cnt_d, sat_cnt_q;
    logic [1:0]             cfg_prec_d, cfg_prec_q;
    logic [SHIFT_W-1:0]     cfg_shift_d, cfg_shift_q;
    logic                   cfg_linear_d, cfg_linear_q;
    logic [3:0]             p_s;
    logic [3:0]             kp_s;
    logic [1:0]             last_k_s;
    logic [CNT_W-1:0]       sat_sum_s;
    logic [SAT_CNT_W:0]     sat_ext_s;
    logic [SAT_CNT_W-1:0]   sat_next_s;
    logic [7:0]             lane_q_s [LANES];
    logic                   lane_sat_s [LANES];

    // The whole pipeline stalls only while a presented word is refused.
    assign en_s   = ~out_vld_q | out_rdy;
    assign busy_s = s1_vld_q | s2_vld_q | (k_q != 2'd0) | out_vld_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        act_quant_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .SHIFT_W    (SHIFT_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en     (en_s),
            .shift  (cfg_shift_q),
            .prec   (cfg_prec_q),
            .linear (cfg_linear_q),
            .x      (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .q      (lane_q_s[i]),
            .sat    (lane_sat_s[i])
        );
    end

    // Valid/last tags travel alongside the lane registers.
    always_comb begin
        if (en_s) begin
            s1_vld_d  = in_vld;
            s1_last_d = in_vld & in_last;
            s2_vld_d  = s1_vld_q;
            s2_last_d = s1_last_q;
        end else begin
            s1_vld_d  = s1_vld_q;
            s1_last_d = s1_last_q;
            s2_vld_d  = s2_vld_q;
            s2_last_d = s2_last_q;
        end
    end

    // Merge the current beat into the partial word at slot k of every lane byte.
    always_comb begin
        p_s  = prec_bits(cfg_prec_q);
        kp_s = {2'b00, k_q} * p_s;
        case (cfg_prec_q)
            PREC_2B: last_k_s = 2'd3;
            PREC_4B: last_k_s = 2'd1;
            default: last_k_s = 2'd0;
        endcase
        word_s = '0;
        for (int i = 0; i < LANES; i++) begin
            word_s[i*8 +: 8] = pack_q[i*8 +: 8] | (lane_q_s[i] << kp_s);
        end
    end

    // Packer and output register: emit on the final slot or on a last beat.
    always_comb begin
        pack_d     = pack_q;
        k_d        = k_q;
        out_data_d = out_data_q;
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;
        if (en_s) begin
            out_vld_d = 1'b0;
            if (s2_vld_q) begin
                if ((k_q == last_k_s) || s2_last_q) begin
                    out_data_d = word_s;
                    out_vld_d  = 1'b1;
                    out_last_d = s2_last_q;
                    pack_d     = '0;
                    k_d        = 2'd0;
                end else begin
                    pack_d = word_s;
                    k_d    = k_q + 2'd1;
                end
            end else begin
                pack_d = pack_q;
            end
        end else begin
            out_vld_d = out_vld_q;
        end
    end

    // Count lanes that clipped at the top of the range in the beat being packed.
    always_comb begin
        sat_sum_s = '0;
        for (int i = 0; i < LANES; i++) begin
            sat_sum_s = sat_sum_s + CNT_W'(lane_sat_s[i]);
        end
        sat_ext_s = {1'b0, sat_cnt_q} + (SAT_CNT_W+1)'(sat_sum_s);
        if (sat_ext_s[SAT_CNT_W]) begin
            sat_next_s = '1;
        end else begin
            sat_next_s = sat_ext_s[SAT_CNT_W-1:0];
        end
    end

    // Config is only swapped while the block is fully idle; loading clears the counter.
    always_comb begin
        cfg_prec_d   = cfg_prec_q;
        cfg_shift_d  = cfg_shift_q;
        cfg_linear_d = cfg_linear_q;
        sat_cnt_d    = sat_cnt_q;
        if (cfg_load && !busy_s && !in_vld) begin
            cfg_prec_d   = cfg_prec;
            cfg_shift_d  = cfg_shift;
            cfg_linear_d = cfg_linear;
            sat_cnt_d    = '0;
        end else if (en_s && s2_vld_q) begin
            sat_cnt_d = sat_next_s;
        end else begin
            sat_cnt_d = sat_cnt_q;
        end
    end

    // All control and datapath state of the top, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q     <= 1'b0;
            s1_last_q    <= 1'b0;
            s2_vld_q     <= 1'b0;
            s2_last_q    <= 1'b0;
            k_q          <= 2'd0;
            pack_q       <= '0;
            out_data_q   <= '0;
            out_vld_q    <= 1'b0;
            out_last_q   <= 1'b0;
            sat_cnt_q    <= '0;
            cfg_prec_q   <= PREC_8B;
            cfg_shift_q  <= '0;
            cfg_linear_q <= 1'b0;
        end else begin
            s1_vld_q     <= s1_vld_d;
            s1_last_q    <= s1_last_d;
            s2_vld_q     <= s2_vld_d;
            s2_last_q    <= s2_last_d;
            k_q          <= k_d;
            pack_q       <= pack_d;
            out_data_q   <= out_data_d;
            out_vld_q    <= out_vld_d;
            out_last_q   <= out_last_d;
            sat_cnt_q    <= sat_cnt_d;
            cfg_prec_q   <= cfg_prec_d;
            cfg_shift_q  <= cfg_shift_d;
            cfg_linear_q <= cfg_linear_d;
        end
    end

    assign in_rdy   = en_s;
    assign busy     = busy_s;
    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_last = out_last_q;
    assign sat_cnt  = sat_cnt_q;

endmodule

// File: tb/tb_act_quant_pack_array.sv
// Scoreboard bench for act_quant_pack_array with directed vectors.
module tb_act_quant_pack_array;

    localparam int DW = 28;
    localparam int LN = 16;
    localparam int SW = 4;
    localparam int CW = 16;

    typedef struct packed {
        logic         last;
        logic [127:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_load;
    logic [1:0]        cfg_prec;
    logic [SW-1:0]     cfg_shift;
    logic              cfg_linear;
    logic              in_vld;
    logic              in_rdy;
    logic              in_last;
    logic [DW*LN-1:0]  in_data;
    logic              out_vld;
    logic              out_rdy;
    logic [8*LN-1:0]   out_data;
    logic              out_last;
    logic [CW-1:0]     sat_cnt;
    logic              busy;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [DW*LN-1:0] bd;
    logic [127:0]     ew;
    logic             prev_held = 1'b0;
    logic [127:0]     prev_data = '0;

    act_quant_pack_array dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_prec(cfg_prec),
        .cfg_shift(cfg_shift), .cfg_linear(cfg_linear), .in_vld(in_vld),
        .in_rdy(in_rdy), .in_last(in_last), .in_data(in_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .out_last(out_last), .sat_cnt(sat_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted word and checks hold behaviour.
    always @(negedge clk) begin
        if (!rst && out_vld) begin
            if (out_rdy) begin
                prev_held = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", {127'd0, out_last}, {127'd0, e.last});
                end
            end else begin
                check("in_rdy_held", {127'd0, in_rdy}, 128'd0);
                if (prev_held) check("hold_stable", out_data, prev_data);
                prev_held = 1'b1;
                prev_data = out_data;
            end
        end else begin
            prev_held = 1'b0;
        end
    end

    task automatic push(input logic [127:0] d, input logic last);
        exp_t e;
        e.data = d;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic send_beat(input logic [DW*LN-1:0] d, input logic last);
        int n;
        in_data = d;
        in_last = last;
        in_vld  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_rdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_rdy=0 expected 1");
        end
        @(posedge clk);
        #1;
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 expected 0");
        end
    endtask

    task automatic do_cfg(input logic [1:0] p, input logic [SW-1:0] s, input logic lin);
        wait_idle();
        cfg_prec   = p;
        cfg_shift  = s;
        cfg_linear = lin;
        cfg_load   = 1'b1;
        @(posedge clk);
        #1;
        cfg_load   = 1'b0;
    endtask

    function automatic logic [DW*LN-1:0] lane0(input logic [DW-1:0] v);
        logic [DW*LN-1:0] r;
        r = '0;
        r[DW-1:0] = v;
        return r;
    endfunction

    initial begin
        int lat;
        rst = 1'b1; cfg_load = 1'b0; cfg_prec = 2'b10; cfg_shift = '0;
        cfg_linear = 1'b0; in_vld = 1'b0; in_last = 1'b0; in_data = '0;
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_vld", {127'd0, out_vld}, 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_out_last", {127'd0, out_last}, 128'd0);
        check("rst_sat_cnt", {112'd0, sat_cnt}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_in_rdy", {127'd0, in_rdy}, 128'd1);
        @(posedge clk);
        #1;

        // 8b ReLU, shift 4: rounding, negative to zero, upper saturation, latency
        do_cfg(2'b10, 4'd4, 1'b0);
        bd = '0;
        bd[0*DW +: DW] = 28'sd248;
        bd[1*DW +: DW] = -28'sd40;
        bd[2*DW +: DW] = 28'sh1000;
        ew = '0; ew[7:0] = 8'h10; ew[15:8] = 8'h00; ew[23:16] = 8'hFF;
        push(ew, 1'b0);
        send_beat(bd, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_vld && lat < 20);
        check("latency", 128'(lat), 128'd3);
        wait_idle();
        check("sat_8b", {112'd0, sat_cnt}, 128'd1);

        // 4b linear, shift 0: two-beat word, then a single last beat that saturates
        do_cfg(2'b01, 4'd0, 1'b1);
        check("sat_cleared", {112'd0, sat_cnt}, 128'd0);
        ew = '0; ew[7:0] = 8'hE3; push(ew, 1'b0);
        send_beat(lane0(28'sd3), 1'b0);
        send_beat(lane0(-28'sd2), 1'b0);
        ew = '0; ew[7:0] = 8'h07; push(ew, 1'b1);
        send_beat(lane0(28'sd9), 1'b1);
        wait_idle();
        check("sat_4b_lin", {112'd0, sat_cnt}, 128'd1);

        // 2b ReLU, shift 1: four beats into one word
        do_cfg(2'b00, 4'd1, 1'b0);
        ew = '0; ew[7:0] = 8'hF9; push(ew, 1'b0);
        send_beat(lane0(28'sd2), 1'b0);
        send_beat(lane0(28'sd4), 1'b0);
        send_beat(lane0(28'sd6), 1'b0);
        send_beat(lane0(28'sd100), 1'b0);
        wait_idle();
        check("sat_2b", {112'd0, sat_cnt}, 128'd1);

        // Back-pressure: 10-beat 8b stream with out_rdy dropped for five cycles
        do_cfg(2'b10, 4'd0, 1'b0);
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    bd = '0;
                    bd[0*DW +: DW] = DW'(i + 1);
                    bd[5*DW +: DW] = DW'(200 - i);
                    ew = '0;
                    ew[7:0]   = 8'(i + 1);
                    ew[47:40] = 8'(200 - i);
                    push(ew, (i == 9));
                    send_beat(bd, (i == 9));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_rdy = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_rdy = 1'b1;
            end
        join
        wait_idle();
        check("bp_sat", {112'd0, sat_cnt}, 128'd0);

        // cfg_load while busy is ignored; after draining it applies and clears sat_cnt
        bd = '0;
        bd[0*DW +: DW] = 28'sd5;
        bd[1*DW +: DW] = 28'sd300;
        ew = '0; ew[7:0] = 8'h05; ew[15:8] = 8'hFF; push(ew, 1'b0);
        send_beat(bd, 1'b0);
        cfg_prec = 2'b00; cfg_shift = 4'd1; cfg_linear = 1'b1; cfg_load = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        ew = '0; ew[7:0] = 8'h07; push(ew, 1'b0);
        send_beat(lane0(28'sd7), 1'b0);
        wait_idle();
        check("busy_load_sat", {112'd0, sat_cnt}, 128'd1);
        do_cfg(2'b01, 4'd0, 1'b0);
        check("load_clears_sat", {112'd0, sat_cnt}, 128'd0);
        ew = '0; ew[7:0] = 8'h21; push(ew, 1'b0);
        send_beat(lane0(28'sd1), 1'b0);
        send_beat(lane0(28'sd2), 1'b0);
        wait_idle();

        // Reset with a partial 2b word pending, then a fresh four-beat group
        do_cfg(2'b00, 4'd0, 1'b0);
        send_beat(lane0(28'sd1), 1'b0);
        send_beat(lane0(28'sd2), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("partial_busy", {127'd0, busy}, 128'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", {127'd0, busy}, 128'd0);
        check("mid_rst_out_vld", {127'd0, out_vld}, 128'd0);
        @(posedge clk);
        #1;
        do_cfg(2'b00, 4'd0, 1'b0);
        ew = '0; ew[7:0] = 8'h39; push(ew, 1'b0);
        send_beat(lane0(28'sd1), 1'b0);
        send_beat(lane0(28'sd2), 1'b0);
        send_beat(lane0(28'sd3), 1'b0);
        send_beat(lane0(28'sd0), 1'b0);
        wait_idle();
        repeat (2) @(posedge clk);
        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
